// File: rtl/bias_channel_sequencer_if.sv
// bias_channel_sequencer_if: product stream, bias adder link and result handshake.
interface bias_channel_sequencer_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 35
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic [ACC_W-1:0]  acc_out;
    logic [1:0]        bias_sel;
    logic [ACC_W-1:0]  bias_res;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [1:0]        res_ch;
    modport master (
        output prod_valid, prod_data, bias_res, res_ready,
        input  prod_ready, acc_out, bias_sel, res_valid, res_data, res_ch
    );
    modport slave (
        input  prod_valid, prod_data, bias_res, res_ready,
        output prod_ready, acc_out, bias_sel, res_valid, res_data, res_ch
    );
endinterface

// File: rtl/bias_channel_sequencer.sv
// bias_channel_sequencer: accumulates N_TAPS products per channel, adds the channel bias
// through an external adder and emits one result per channel over valid/ready.
module bias_channel_sequencer #(
    parameter int N_TAPS = 9,
    parameter int N_CH   = 4,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    bias_channel_sequencer_if.slave  bus
);
    localparam int TW = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, OUT, DONE} state_t;
    state_t           r_state, w_next;
    logic [ACC_W-1:0] r_acc, r_res_data;
    logic [TW-1:0]    r_tap;
    logic [1:0]       r_ch, r_res_ch;
    logic             w_fire, w_last_tap, w_last_ch, w_accept;
    assign w_fire     = r_state == ACCUM && bus.prod_valid;
    assign w_last_tap = r_tap == TW'(N_TAPS - 1);
    assign w_last_ch  = r_ch == 2'(N_CH - 1);
    assign w_accept   = r_state == OUT && bus.res_ready;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ACCUM : IDLE;
            ACCUM:   w_next = w_fire && w_last_tap ? BIAS : ACCUM;
            BIAS:    w_next = OUT;
            OUT:     w_next = bus.res_ready ? (w_last_ch ? DONE : ACCUM) : OUT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Channel restarts (run start or non-final accept) clear the accumulator and tap count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_tap      <= '0;
            r_ch       <= '0;
            r_res_data <= '0;
            r_res_ch   <= '0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_acc <= '0;
                r_tap <= '0;
                r_ch  <= '0;
            end
            if (w_fire) begin
                r_acc <= r_acc + {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
                r_tap <= r_tap + 1'b1;
            end
            if (r_state == BIAS) begin
                r_res_data <= bus.bias_res;
                r_res_ch   <= r_ch;
            end
            if (w_accept && !w_last_ch) begin
                r_acc <= '0;
                r_tap <= '0;
                r_ch  <= r_ch + 2'd1;
            end
        end
    end
    assign o_busy         = r_state != IDLE;
    assign o_done         = r_state == DONE;
    assign bus.prod_ready = r_state == ACCUM;
    assign bus.res_valid  = r_state == OUT;
    assign bus.res_data   = r_res_data;
    assign bus.res_ch     = r_res_ch;
    assign bus.acc_out    = r_acc;
    assign bus.bias_sel   = r_ch;
endmodule

// File: tb/tb_bias_channel_sequencer.sv
// tb_bias_channel_sequencer: drives product runs against a sum-plus-bias reference model.
module tb_bias_channel_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    int   n_err = 0;
    int   n_chk = 0;
    int   n_done = 0;
    logic [34:0] bias_tbl [4] = '{35'h0959B3D08, 35'h7FFFFFFBE, 35'h0EE00D1B7, 35'h01A305532};
    logic [34:0] exp_ones [4] = '{35'h0959B3D11, 35'h7FFFFFFC7, 35'h0EE00D1C0, 35'h01A30553B};
    bias_channel_sequencer_if #(.PROD_W(32), .ACC_W(35)) bus ();
    bias_channel_sequencer #(.N_TAPS(9), .N_CH(4), .PROD_W(32), .ACC_W(35)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    // External bias adder: operand plus per-channel bias, wrapping at 35 bits.
    always_comb bus.bias_res = bus.acc_out + bias_tbl[bus.bias_sel];
    always @(negedge clk) if (done) n_done++;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic chk_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod_ready", 64'(bus.prod_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_res_ch", 64'(bus.res_ch), 64'd0);
        chk("rst_bias_sel", 64'(bus.bias_sel), 64'd0);
        chk("rst_acc_out", 64'(bus.acc_out), 64'd0);
    endtask
    task automatic do_run(input int mode, input bit gaps, input int hold_ch, input bit abort,
                          input bit start_hold);
        logic [34:0] sum;
        logic [31:0] d;
        int k;
        int d0;
        bit pv;
        d0 = n_done;
        start = 1'b1;
        @(negedge clk);
        if (!start_hold) start = 1'b0;
        chk("busy_start", 64'(busy), 64'd1);
        for (int ch = 0; ch < 4; ch++) begin
            sum = '0;
            k = 0;
            while (k < 9) begin
                pv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                d = mode == 2 ? $urandom : (mode == 1 && ch == 0) ? 32'hFFFFFFFF : 32'd1;
                bus.prod_valid = pv;
                bus.prod_data = d;
                chk("prod_ready", 64'(bus.prod_ready), 64'd1);
                chk("acc_out", 64'(bus.acc_out), 64'(sum));
                chk("bias_sel", 64'(bus.bias_sel), 64'(ch));
                if (pv) begin
                    sum += {{3{d[31]}}, d};
                    k++;
                end
                @(negedge clk);
                if (abort && ch == 2 && k == 4) begin
                    bus.prod_valid = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_reset();
                    chk("abort_no_done", 64'(n_done - d0), 64'd0);
                    return;
                end
            end
            bus.prod_valid = 1'b0;
            chk("bias_res_valid", 64'(bus.res_valid), 64'd0);
            chk("bias_prod_ready", 64'(bus.prod_ready), 64'd0);
            chk("acc_final", 64'(bus.acc_out), 64'(sum));
            @(negedge clk);
            chk("res_valid", 64'(bus.res_valid), 64'd1);
            chk("res_data", 64'(bus.res_data), 64'(35'(sum + bias_tbl[ch])));
            if (mode == 0) chk("res_const", 64'(bus.res_data), 64'(exp_ones[ch]));
            chk("res_ch", 64'(bus.res_ch), 64'(ch));
            if (ch == hold_ch) begin
                bus.res_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", 64'(bus.res_valid), 64'd1);
                    chk("hold_data", 64'(bus.res_data), 64'(35'(sum + bias_tbl[ch])));
                    chk("hold_ch", 64'(bus.res_ch), 64'(ch));
                    chk("hold_prod_ready", 64'(bus.prod_ready), 64'd0);
                end
                bus.res_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        @(negedge clk);
        if (start_hold) start = 1'b0;
        chk("done_clear", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("done_count", 64'(n_done - d0), 64'd1);
        @(negedge clk);
        chk("no_restart", 64'(busy), 64'd0);
    endtask
    initial begin
        bus.prod_valid = 1'b0;
        bus.prod_data = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy0", 64'(busy), 64'd0);
        do_run(0, 1'b0, -1, 1'b0, 1'b0);
        do_run(1, 1'b0, -1, 1'b0, 1'b0);
        do_run(0, 1'b0, 1, 1'b0, 1'b0);
        do_run(0, 1'b1, -1, 1'b0, 1'b0);
        do_run(0, 1'b0, -1, 1'b1, 1'b0);
        do_run(0, 1'b0, -1, 1'b0, 1'b0);
        do_run(0, 1'b0, -1, 1'b0, 1'b1);
        repeat (3) do_run(2, 1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
